fir_decimator: RTL and testbench

FIR_DECIMATOR -- requirements
Module: fir_decimator

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_decim_regs.sv | 92 +++++++++
 rtl/fir_decimator.sv | 124 ++++++++++++
 tb/tb_fir_decimator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, state encoding and helpers for the decimating
// stream stage behind the FIR filter.
package fir_pkg;

    localparam int MAX_DECIM = 16;

    localparam int ADDR_CTRL  = 'h00;
    localparam int ADDR_DECIM = 'h10;
    localparam int ADDR_COUNT = 'h14;

    localparam int BIT_START = 0;
    localparam int BIT_DONE  = 1;
    localparam int BIT_IDLE  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [4:0] clamp_decim(input logic [4:0] v);
        return (v > 5'(MAX_DECIM)) ? 5'(MAX_DECIM) : v;
    endfunction

    // 0 and 1 both select pass-through
    function automatic logic [4:0] eff_decim(input logic [4:0] v);
        return (v < 5'd2) ? 5'd1 : v;
    endfunction

endpackage

// File: rtl/fir_decim_regs.sv
// AXI-Lite register file: control/status, decimation factor and
// output beat count.
module fir_decim_regs
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   run,
    input  logic                   done,
    input  logic [31:0]            count,
    output logic                   start,
    output logic                   done_clr,
    output logic [4:0]             decim
);

    localparam logic [pADDR_WIDTH-1:0] A_CTRL  = pADDR_WIDTH'(ADDR_CTRL);
    localparam logic [pADDR_WIDTH-1:0] A_DECIM = pADDR_WIDTH'(ADDR_DECIM);
    localparam logic [pADDR_WIDTH-1:0] A_COUNT = pADDR_WIDTH'(ADDR_COUNT);

    logic                   wr_fire;
    logic                   rd_ctrl;
    logic                   is_ctrl;
    logic                   is_decim;
    logic                   is_count;
    logic [pDATA_WIDTH-1:0] read_data;
    logic                   unused_wdata;

    assign wr_fire  = awready && awvalid && wvalid;
    assign start    = wr_fire && (awaddr == A_CTRL) && wdata[BIT_START];
    assign done_clr = rvalid && rready && rd_ctrl;

    assign unused_wdata = ^wdata[pDATA_WIDTH-1:5];

    assign is_ctrl  = (araddr == A_CTRL);
    assign is_decim = (araddr == A_DECIM);
    assign is_count = (araddr == A_COUNT);

    always_comb begin
        read_data = '0;
        unique case (1'b1)
            is_ctrl: begin
                read_data[BIT_DONE] = done;
                read_data[BIT_IDLE] = !run;
            end
            is_decim: read_data[4:0] = decim;
            is_count: read_data = pDATA_WIDTH'(count);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rd_ctrl <= 1'b0;
            decim   <= 5'd1;
        end else begin
            awready <= awvalid && wvalid && !awready;
            wready  <= awvalid && wvalid && !awready;
            // factor is frozen while a run uses it
            if (wr_fire && (awaddr == A_DECIM) && !run)
                decim <= clamp_decim(wdata[4:0]);
            arready <= arvalid && !arready && !rvalid;
            if (arready && arvalid) begin
                rvalid  <= 1'b1;
                rdata   <= read_data;
                rd_ctrl <= is_ctrl;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fir_decimator.sv
// Keeps every M-th beat of the FIR output stream (plus the tlast
// beat) behind a one-deep output register, under AXI-Lite control.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                          axis_clk,
    input  logic                          axis_rst_n,
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [pADDR_WIDTH-1:0]        awaddr,
    input  logic                          wvalid,
    output logic                          wready,
    input  logic [pDATA_WIDTH-1:0]        wdata,
    input  logic                          arvalid,
    output logic                          arready,
    input  logic [pADDR_WIDTH-1:0]        araddr,
    output logic                          rvalid,
    input  logic                          rready,
    output logic [pDATA_WIDTH-1:0]        rdata,
    input  logic                          ss_tvalid,
    input  logic signed [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                          ss_tlast,
    output logic                          ss_tready,
    output logic                          sm_tvalid,
    output logic signed [pDATA_WIDTH-1:0] sm_tdata,
    output logic                          sm_tlast,
    input  logic                          sm_tready
);

    state_t      state;
    logic        done;
    logic [4:0]  m_lat;
    logic [4:0]  phase;
    logic [31:0] count;
    logic        start;
    logic        done_clr;
    logic [4:0]  decim;
    logic        run;
    logic        in_fire;
    logic        out_fire;
    logic        fwd;

    fir_decim_regs #(
        .pADDR_WIDTH(pADDR_WIDTH),
        .pDATA_WIDTH(pDATA_WIDTH)
    ) u_regs (
        .clk      (axis_clk),
        .rst_n    (axis_rst_n),
        .awvalid  (awvalid),
        .awready  (awready),
        .awaddr   (awaddr),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .arvalid  (arvalid),
        .arready  (arready),
        .araddr   (araddr),
        .rvalid   (rvalid),
        .rready   (rready),
        .rdata    (rdata),
        .run      (run),
        .done     (done),
        .count    (count),
        .start    (start),
        .done_clr (done_clr),
        .decim    (decim)
    );

    assign run       = (state == ST_RUN);
    assign ss_tready = run && (!sm_tvalid || sm_tready);
    assign in_fire   = ss_tvalid && ss_tready;
    assign out_fire  = sm_tvalid && sm_tready;
    assign fwd       = in_fire && ((phase == 5'd0) || ss_tlast);

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state     <= ST_IDLE;
            done      <= 1'b0;
            m_lat     <= 5'd1;
            phase     <= 5'd0;
            count     <= 32'd0;
            sm_tvalid <= 1'b0;
            sm_tdata  <= '0;
            sm_tlast  <= 1'b0;
        end else begin
            // load and drain may coincide, giving one beat per cycle
            if (fwd) begin
                sm_tvalid <= 1'b1;
                sm_tdata  <= ss_tdata;
                sm_tlast  <= ss_tlast;
            end else if (out_fire) begin
                sm_tvalid <= 1'b0;
            end
            if (out_fire)
                count <= count + 32'd1;
            if (in_fire)
                phase <= (phase == m_lat - 5'd1) ? 5'd0 : phase + 5'd1;
            if (done_clr)
                done <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_RUN;
                        done  <= 1'b0;
                        m_lat <= eff_decim(decim);
                        phase <= 5'd0;
                        count <= 32'd0;
                    end
                end
                ST_RUN: begin
                    if (out_fire && sm_tlast) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
// Randomized bench for fir_decimator against a keep-every-M-th-beat
// reference built from plain arrays.
module tb_fir_decimator;

    logic               axis_clk = 1'b0;
    logic               axis_rst_n;
    logic               awvalid, awready, wvalid, wready;
    logic [11:0]        awaddr, araddr;
    logic [31:0]        wdata, rdata;
    logic               arvalid, arready, rvalid, rready;
    logic               ss_tvalid, ss_tlast, ss_tready;
    logic signed [31:0] ss_tdata, sm_tdata;
    logic               sm_tvalid, sm_tlast, sm_tready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 axis_clk = ~axis_clk;

    fir_decimator #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .ss_tvalid  (ss_tvalid),
        .ss_tdata   (ss_tdata),
        .ss_tlast   (ss_tlast),
        .ss_tready  (ss_tready),
        .sm_tvalid  (sm_tvalid),
        .sm_tdata   (sm_tdata),
        .sm_tlast   (sm_tlast),
        .sm_tready  (sm_tready)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic axil_write(input logic [11:0] addr, input logic [31:0] data);
        bit hit = 0;
        @(negedge axis_clk);
        awaddr = addr; wdata = data; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 20 && !hit; i++) begin
            #1;
            if (awready && wready) hit = 1;
            else @(negedge axis_clk);
        end
        @(negedge axis_clk);
        awvalid = 0; wvalid = 0;
        check("aw_handshake", 32'(hit), 32'd1);
    endtask

    task automatic axil_read(input logic [11:0] addr, output logic [31:0] data);
        bit hit = 0;
        bit got = 0;
        data = '0;
        @(negedge axis_clk);
        araddr = addr; arvalid = 1; rready = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            #1;
            if (arready) hit = 1;
            else @(negedge axis_clk);
        end
        @(negedge axis_clk);
        arvalid = 0; rready = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (rvalid) begin
                got = 1;
                data = rdata;
            end else begin
                @(negedge axis_clk);
            end
        end
        @(negedge axis_clk);
        rready = 0;
        check("ar_handshake", 32'(hit), 32'd1);
        check("r_valid", 32'(got), 32'd1);
    endtask

    task automatic read_check(input string tag, input logic [11:0] addr,
                              input logic [31:0] exp);
        logic [31:0] d;
        axil_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic run_stream(input string tag, input int n, input int m,
                              input bit rnd, input bit stall, input bit poke);
        logic [31:0] xs[$];
        logic [31:0] exp_d[$];
        bit          exp_l[$];
        int          me, total, idx, nout, first, lastacc;
        bit          done_out, prev_stall, pl;
        logic [31:0] pd;
        me = (m <= 1) ? 1 : ((m > 16) ? 16 : m);
        for (int i = 0; i < n; i++)
            xs.push_back(rnd ? $urandom : 32'(i));
        for (int i = 0; i < n; i++) begin
            if (i % me == 0 || i == n - 1) begin
                exp_d.push_back(xs[i]);
                exp_l.push_back(i == n - 1);
            end
        end
        total = exp_d.size();
        axil_write(12'h010, 32'(m));
        axil_write(12'h000, 32'd1);
        read_check({tag, "_ctrl_run"}, 12'h000, 32'h0);
        if (poke) begin
            axil_write(12'h010, 32'd7);
            read_check({tag, "_decim_locked"}, 12'h010, 32'(m));
        end
        idx = 0; nout = 0; first = -1; lastacc = -1;
        done_out = 0; prev_stall = 0; pd = '0; pl = 0;
        for (int cyc = 0; cyc < 20000 && !done_out; cyc++) begin
            @(negedge axis_clk);
            sm_tready = stall ? ((cyc / 3) % 2 == 1) : 1'b1;
            if (idx < n) begin
                ss_tvalid = 1; ss_tdata = xs[idx]; ss_tlast = (idx == n - 1);
            end else begin
                ss_tvalid = 0; ss_tlast = 0;
            end
            #1;
            if (prev_stall) begin
                check({tag, "_hold_valid"}, 32'(sm_tvalid), 32'd1);
                check({tag, "_hold_data"}, sm_tdata, pd);
                check({tag, "_hold_last"}, 32'(sm_tlast), 32'(pl));
            end
            if (sm_tvalid && sm_tready) begin
                if (nout < total) begin
                    check({tag, "_data"}, sm_tdata, exp_d[nout]);
                    check({tag, "_last"}, 32'(sm_tlast), 32'(exp_l[nout]));
                end else begin
                    check({tag, "_extra_beat"}, 32'(nout + 1), 32'(total));
                end
                nout++;
                if (sm_tlast) done_out = 1;
            end
            if (ss_tvalid && ss_tready) begin
                if (first < 0) first = cyc;
                lastacc = cyc;
                idx++;
            end
            prev_stall = sm_tvalid && !sm_tready;
            pd = sm_tdata;
            pl = sm_tlast;
        end
        @(negedge axis_clk);
        ss_tvalid = 0; ss_tlast = 0; sm_tready = 1;
        check({tag, "_out_count"}, 32'(nout), 32'(total));
        check({tag, "_in_count"}, 32'(idx), 32'(n));
        if (!stall)
            check({tag, "_throughput"}, 32'(lastacc - first + 1), 32'(n));
        read_check({tag, "_reg_count"}, 12'h014, 32'(total));
        read_check({tag, "_ctrl_done"}, 12'h000, 32'h6);
        read_check({tag, "_ctrl_after"}, 12'h000, 32'h4);
    endtask

    task automatic reset_mid_run();
        int idx = 0;
        axil_write(12'h010, 32'd2);
        axil_write(12'h000, 32'd1);
        for (int cyc = 0; cyc < 50 && idx < 5; cyc++) begin
            @(negedge axis_clk);
            sm_tready = 1; ss_tvalid = 1; ss_tdata = 32'(idx); ss_tlast = 0;
            #1;
            if (ss_tready) idx++;
        end
        @(negedge axis_clk);
        ss_tvalid = 0; sm_tready = 0;
        #1;
        check("rst_in_count", 32'(idx), 32'd5);
        check("rst_pre_valid", 32'(sm_tvalid), 32'd1);
        check("rst_pre_data", sm_tdata, 32'd4);
        #2 axis_rst_n = 0;
        #1;
        check("rst_valid", 32'(sm_tvalid), 32'd0);
        check("rst_data", sm_tdata, 32'd0);
        check("rst_ss_ready", 32'(ss_tready), 32'd0);
        @(negedge axis_clk);
        axis_rst_n = 1;
        read_check("rst_ctrl", 12'h000, 32'h4);
        read_check("rst_decim", 12'h010, 32'd1);
        read_check("rst_count", 12'h014, 32'd0);
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge axis_clk);
            ss_tvalid = 1; sm_tready = 1;
            #1;
            check("rst_no_accept", 32'(ss_tready), 32'd0);
            check("rst_no_out", 32'(sm_tvalid), 32'd0);
        end
        @(negedge axis_clk);
        ss_tvalid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axis_rst_n = 0;
        awvalid = 0; wvalid = 0; awaddr = '0; wdata = '0;
        arvalid = 0; araddr = '0; rready = 0;
        ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0; sm_tready = 0;
        repeat (3) @(negedge axis_clk);
        axis_rst_n = 1;
        #1;
        check("reset_aw_w_ar", {29'd0, awready, wready, arready}, 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_ss_ready", 32'(ss_tready), 32'd0);
        check("reset_sm", {30'd0, sm_tvalid, sm_tlast}, 32'd0);
        check("reset_sm_data", sm_tdata, 32'd0);
        read_check("reset_ctrl", 12'h000, 32'h4);
        read_check("reset_decim", 12'h010, 32'd1);
        read_check("reset_count", 12'h014, 32'd0);
        read_check("unmapped_read", 12'h020, 32'd0);
        axil_write(12'h010, 32'd31);
        read_check("decim_sat", 12'h010, 32'd16);
        axil_write(12'h020, 32'd5);
        read_check("unmapped_write", 12'h010, 32'd16);

        run_stream("m3", 10, 3, 0, 0, 1);
        run_stream("m4", 6, 4, 0, 0, 0);
        run_stream("m0", 600, 0, 1, 0, 0);
        run_stream("m1", 600, 1, 1, 0, 0);
        run_stream("m2_stall", 50, 2, 1, 1, 0);
        run_stream("m20_sat", 40, 20, 1, 0, 0);
        reset_mid_run();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
